// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised synchronous RAM with byte-lane writes and LATENCY wait states.
// Optional macro DMEM_ALIGN_CHECK_EN adds addr_err and suppresses stores with illegal lane masks.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [3:0]  memsel,
    input  logic [31:0] aluoutM,
    input  logic [31:0] final_writedM,
    input  logic        hold,
    output logic [31:0] readdataM,
    output logic        dmem_stallM
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        addr_err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } stateT;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

    stateT                 state;
    logic [3:0]            waitCnt;
    logic                  capWrite;
    logic [3:0]            capSel;
    logic [ADDR_WIDTH-1:0] capIdx;
    logic [31:0]           capData;

    logic [31:0]           mem [2**ADDR_WIDTH];

    logic                  accFire;
    logic                  accWrite;
    logic [3:0]            accSel;
    logic [ADDR_WIDTH-1:0] accIdx;
    logic [31:0]           accData;
    logic [3:0]            laneEn;
    logic                  unusedAddrBits;

    assign unusedAddrBits = ^{aluoutM[31:ADDR_WIDTH+2], aluoutM[1:0]};

    // With zero wait states the access happens at the request edge, so live inputs feed the array.
    always_comb begin
        accFire  = ((state == IDLE) && memenM && (LATENCY == 0)) ||
                   ((state == WAIT) && (waitCnt == 4'd1));
        accWrite = capWrite;
        accSel   = capSel;
        accIdx   = capIdx;
        accData  = capData;
        if (state == IDLE) begin
            accWrite = memwriteM;
            accSel   = memsel;
            accIdx   = aluoutM[ADDR_WIDTH+1:2];
            accData  = final_writedM;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic selLegal;
    logic accErr;
    logic errReg;

    always_comb begin
        selLegal = (accSel == 4'b0001) || (accSel == 4'b0010) || (accSel == 4'b0100) ||
                   (accSel == 4'b1000) || (accSel == 4'b0011) || (accSel == 4'b1100) ||
                   (accSel == 4'b1111);
        accErr   = accWrite && !selLegal;
        laneEn   = accErr ? 4'b0000 : accSel;
    end

    assign addr_err = errReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            errReg <= 1'b0;
        end else if (accFire) begin
            errReg <= accErr;
        end else if ((state == DONE) && !hold) begin
            errReg <= 1'b0;
        end
    end
`else
    assign laneEn = accSel;
`endif

    assign dmem_stallM = ((state == IDLE) && memenM) || (state == WAIT);

    // Array is not reset; a reset in the access cycle abandons the store.
    always_ff @(posedge clk) begin
        if (!rst && accFire && accWrite) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (laneEn[i]) begin
                    mem[accIdx][8*i +: 8] <= accData[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            waitCnt   <= '0;
            readdataM <= '0;
            capWrite  <= 1'b0;
            capSel    <= '0;
            capIdx    <= '0;
            capData   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memenM) begin
                        capWrite <= memwriteM;
                        capSel   <= memsel;
                        capIdx   <= aluoutM[ADDR_WIDTH+1:2];
                        capData  <= final_writedM;
                        waitCnt  <= LAT_LOAD;
                        state    <= (LATENCY == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!hold) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (accFire && !accWrite) begin
                readdataM <= mem[accIdx];
            end
        end
    end

endmodule
